// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared types for the ALU instruction-queue core: opcode
//            encoding, controller state encoding and opcode helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int OP_W = 3;

  // Opcode encoding as seen on the op input and stored in the queue.
  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_EQ   = 3'b100,
    OP_GT   = 3'b101,
    OP_LT   = 3'b110,
    OP_ZERO = 3'b111
  } alu_op_e;

  // Controller states: waiting for work, computing, presenting a result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Only arithmetic and bitwise results carry a meaningful sign bit;
  // compare/zero-test results are plain 0/1 booleans.
  function automatic logic op_has_sign(input alu_op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : alu_queue_fifo
// Purpose  : Circular-buffer instruction queue of DEPTH entries, DW bits each.
// Ports    : clk_i, rst_ni (async, active-low)
//            push_i/wdata_i : enqueue request and entry (ignored when full)
//            pop_i          : dequeue request (ignored when empty)
//            rdata_o        : current head entry
//            full_o, empty_o, count_o : occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module alu_queue_fifo #(
  parameter int DW    = 15,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [DW-1:0]          wdata_i,
  input  logic                   pop_i,
  output logic [DW-1:0]          rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;

  logic push_ok;
  logic pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push against a full queue is refused even if a pop happens on the
  // same edge: acceptance is judged on the occupancy before the edge.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // DEPTH is a power of two, so natural pointer overflow is the wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + (AW+1)'(1);
      else if (!push_ok && pop_ok) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/alu_queue_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_queue_core
// Purpose  : Queued signed ALU. Instructions {a, b, op} are enqueued, popped
//            one at a time (continuously or per step pulse), executed and
//            presented with a valid/ready handshake.
// Ports    : clock, rstsync (async, active-low)
//            push, op, a, b        : enqueue an instruction
//            run_mode, step        : continuous vs single-step execution
//            res_ready             : consumer acceptance
//            res_valid, res, neg_a, neg_b, neg_r, ovf : result and flags
//            full, empty, count, drop_err           : queue status
// Revision : 1.0 - initial release
// ============================================================================
module alu_queue_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   rstsync,
  input  logic                   push,
  input  logic [2:0]             op,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   run_mode,
  input  logic                   step,
  input  logic                   res_ready,
  output logic                   res_valid,
  output logic [WIDTH-1:0]       res,
  output logic                   neg_a,
  output logic                   neg_b,
  output logic                   neg_r,
  output logic                   ovf,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drop_err
);

  localparam int EW = 2 * WIDTH + OP_W;

  // Queue entry layout: {op, a, b}
  logic [EW-1:0] wdata;
  logic [EW-1:0] head;
  logic          pop;

  assign wdata = {op, a, b};

  alu_queue_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (rstsync),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  alu_state_e       state_q, state_d;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_q;
  logic             neg_a_q, neg_b_q, neg_r_q, ovf_q;
  logic             drop_q;

  // Next-state logic. A step outside IDLE or with an empty queue simply
  // has no effect; nothing is stored for later.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty && (run_mode || step)) begin
          pop     = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Arithmetic on the latched operands.
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      // Overflow: operands of equal sign produce a sum of the other sign.
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      // Overflow: operands of opposite sign produce a difference whose sign
      // differs from the minuend.
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
      OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) > $signed(b_q))};
      OP_LT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_ZERO: alu_res = {{(WIDTH-1){1'b0}}, (a_q == '0)};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge rstsync) begin
    if (!rstsync) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      neg_r_q <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        op_q <= alu_op_e'(head[EW-1 -: OP_W]);
        a_q  <= head[2*WIDTH-1 -: WIDTH];
        b_q  <= head[WIDTH-1:0];
      end
      // Result and flags change only when leaving EXEC, so they stay put
      // through DONE and keep their last values back in IDLE.
      if (state_q == ST_EXEC) begin
        res_q   <= alu_res;
        ovf_q   <= alu_ovf;
        neg_a_q <= a_q[WIDTH-1];
        neg_b_q <= (op_q == OP_ZERO) ? 1'b0 : b_q[WIDTH-1];
        neg_r_q <= op_has_sign(op_q) ? alu_res[WIDTH-1] : 1'b0;
      end
      if (push && full) drop_q <= 1'b1;
    end
  end

  assign res_valid = (state_q == ST_DONE);
  assign res       = res_q;
  assign neg_a     = neg_a_q;
  assign neg_b     = neg_b_q;
  assign neg_r     = neg_r_q;
  assign ovf       = ovf_q;
  assign drop_err  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_queue_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_queue_core
// Purpose  : Self-checking bench for alu_queue_core (WIDTH=6, DEPTH=8) with
//            directed scenarios followed by randomized traffic, compared
//            against a queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_queue_core;
  import alu_pkg::*;

  localparam int WIDTH = 6;
  localparam int DEPTH = 8;

  logic                   clock;
  logic                   rstsync;
  logic                   push;
  logic [2:0]             op;
  logic [WIDTH-1:0]       a, b;
  logic                   run_mode, step, res_ready;
  logic                   res_valid;
  logic [WIDTH-1:0]       res;
  logic                   neg_a, neg_b, neg_r, ovf;
  logic                   full, empty;
  logic [$clog2(DEPTH):0] count;
  logic                   drop_err;

  alu_queue_core #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .rstsync   (rstsync),
    .push      (push),
    .op        (op),
    .a         (a),
    .b         (b),
    .run_mode  (run_mode),
    .step      (step),
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res       (res),
    .neg_a     (neg_a),
    .neg_b     (neg_b),
    .neg_r     (neg_r),
    .ovf       (ovf),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .drop_err  (drop_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int op; int a; int b; } ent_t;

  ent_t mq[$];
  ent_t m_cur;
  int   m_stage;            // 0 waiting, 1 computing, 2 result presented
  int   m_res;
  bit   m_na, m_nb, m_nr, m_ovf, m_drop;

  function automatic int sx(input int v);
    logic [WIDTH-1:0] t;
    t = v[WIDTH-1:0];
    return int'($signed(t));
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_stage = 0;
    m_res = 0; m_na = 0; m_nb = 0; m_nr = 0; m_ovf = 0; m_drop = 0;
  endfunction

  function automatic void model_exec(input ent_t e);
    int mx, mn, mask, s;
    mx   = (1 << (WIDTH-1)) - 1;
    mn   = -(1 << (WIDTH-1));
    mask = (1 << WIDTH) - 1;
    m_ovf = 0;
    case (e.op)
      0: begin s = e.a + e.b; m_ovf = (s > mx) || (s < mn); m_res = s & mask; end
      1: begin s = e.a - e.b; m_ovf = (s > mx) || (s < mn); m_res = s & mask; end
      2: m_res = (e.a & e.b) & mask;
      3: m_res = (e.a | e.b) & mask;
      4: m_res = (e.a == e.b) ? 1 : 0;
      5: m_res = (e.a >  e.b) ? 1 : 0;
      6: m_res = (e.a <  e.b) ? 1 : 0;
      default: m_res = (e.a == 0) ? 1 : 0;
    endcase
    m_na = (e.a < 0);
    m_nb = (e.op == 7) ? 1'b0 : (e.b < 0);
    m_nr = (e.op <= 3) ? bit'((m_res >> (WIDTH-1)) & 1) : 1'b0;
  endfunction

  // Apply one rising edge to the model using the inputs present at it.
  function automatic void model_edge(input bit p, input int o, input int aa, input int bb,
                                     input bit rm, input bit st, input bit rr);
    bit   was_full;
    ent_t e;
    was_full = (mq.size() == DEPTH);
    if (m_stage == 1) begin
      model_exec(m_cur);
      m_stage = 2;
    end else if (m_stage == 2) begin
      if (rr) m_stage = 0;
    end else if (mq.size() != 0 && (rm || st)) begin
      m_cur   = mq.pop_front();
      m_stage = 1;
    end
    if (p) begin
      if (was_full) m_drop = 1'b1;
      else begin
        e.op = o; e.a = aa; e.b = bb;
        mq.push_back(e);
      end
    end
  endfunction

  task automatic check_all();
    check("count",     count,     mq.size());
    check("empty",     empty,     mq.size() == 0);
    check("full",      full,      mq.size() == DEPTH);
    check("drop_err",  drop_err,  m_drop);
    check("res_valid", res_valid, m_stage == 2);
    check("res",       res,       m_res);
    check("neg_a",     neg_a,     m_na);
    check("neg_b",     neg_b,     m_nb);
    check("neg_r",     neg_r,     m_nr);
    check("ovf",       ovf,       m_ovf);
  endtask

  int rise_q[$];
  int rise_res[$];
  bit prev_rv = 1'b0;

  task automatic cycle(input bit p, input int o, input int aa, input int bb,
                       input bit rm, input bit st, input bit rr);
    push = p; op = o[2:0]; a = aa[WIDTH-1:0]; b = bb[WIDTH-1:0];
    run_mode = rm; step = st; res_ready = rr;
    @(posedge clock);
    model_edge(p, o, sx(aa), sx(bb), rm, st, rr);
    cyc++;
    #1;
    push = 1'b0; step = 1'b0;
    check_all();
    if (res_valid && !prev_rv) begin
      rise_q.push_back(cyc);
      rise_res.push_back(int'(res));
    end
    prev_rv = res_valid;
  endtask

  // Assert reset between edges and verify the outputs clear before the
  // next rising edge; release on the following falling edge.
  task automatic do_reset(input string tag);
    #2;
    rstsync = 1'b0;
    model_reset();
    #1;
    check({tag, "_rv"},    res_valid, 0);
    check({tag, "_count"}, count,     0);
    check({tag, "_empty"}, empty,     1);
    check({tag, "_full"},  full,      0);
    check({tag, "_drop"},  drop_err,  0);
    check({tag, "_res"},   res,       0);
    check({tag, "_flags"}, {neg_a, neg_b, neg_r, ovf}, 0);
    push = 1'b0; step = 1'b0; run_mode = 1'b0; res_ready = 1'b0;
    @(negedge clock);
    rstsync = 1'b1;
    prev_rv = 1'b0;
  endtask

  initial begin
    bit rmode;
    rstsync = 1'b1; push = 1'b0; op = '0; a = '0; b = '0;
    run_mode = 1'b0; step = 1'b0; res_ready = 1'b0;
    model_reset();
    #1;
    do_reset("rst0");

    // ADD overflow, single step, latency check
    cycle(1, OP_ADD, 31, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    check("add_rv_pop_edge", res_valid, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("add_rv",   res_valid, 1);
    check("add_res",  res, 6'b100000);
    check("add_ovf",  ovf, 1);
    check("add_negr", neg_r, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);

    // SUB overflow
    cycle(1, OP_SUB, -32, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("sub_res",  res, 31);
    check("sub_ovf",  ovf, 1);
    check("sub_nega", neg_a, 1);
    check("sub_negr", neg_r, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    // step with empty queue is ignored
    cycle(0, 0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("step_empty_rv", res_valid, 0);

    // GT then LT in run mode
    cycle(1, OP_GT, 5, -3, 0, 0, 1);
    cycle(1, OP_LT, 5, -3, 0, 0, 1);
    rise_q.delete(); rise_res.delete();
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 0, 1);
    check("gtlt_results", rise_q.size(), 2);
    if (rise_q.size() == 2) begin
      check("gtlt_spacing", rise_q[1] - rise_q[0], 3);
      check("gt_res", rise_res[0], 1);
      check("lt_res", rise_res[1], 0);
    end

    // Overfill, then drain in order
    for (int i = 0; i < 9; i++)
      cycle(1, int'($urandom_range(0, 7)), int'($urandom), int'($urandom), 0, 0, 0);
    check("fill_count", count, 8);
    check("fill_full",  full, 1);
    check("fill_drop",  drop_err, 1);
    for (int i = 0; i < 30; i++) cycle(0, 0, 0, 0, 1, 0, 1);
    check("drain_empty", empty, 1);
    check("drain_drop",  drop_err, 1);

    // Result held while consumer stalls
    for (int i = 0; i < 3; i++)
      cycle(1, int'($urandom_range(0, 7)), int'($urandom), int'($urandom), 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 0, 0);
    check("hold_count", count, 2);
    check("hold_rv",    res_valid, 1);

    // Reset while presenting a result
    do_reset("rst_done");

    // Randomized traffic
    rmode = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) rmode = !rmode;
      cycle($urandom_range(0, 9) < 6, int'($urandom_range(0, 7)),
            int'($urandom), int'($urandom),
            rmode, $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
      if (i == 750) do_reset("rst_rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
